traffic_phase_ctrl: RTL



---
 rtl/traffic_phase_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/traffic_phase_ctrl.sv
// Two-way intersection phase sequencer with 1 Hz countdown and ped shortening.
// Optional night flashing mode when NIGHT_MODE_EN is defined.
module traffic_phase_ctrl #(
    parameter int CLK_HZ   = 50000000,
    parameter int T_GREEN  = 25,
    parameter int T_YELLOW = 3,
    parameter int T_ALLRED = 2,
    parameter int T_PED    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       ped_req,
`ifdef NIGHT_MODE_EN
    input  logic       night,
`endif
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [5:0] remain,
    output logic [2:0] phase,
    output logic       sec_tick
);

    localparam int DW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_HZ - 1);
    localparam logic [5:0] D_G = 6'(T_GREEN);
    localparam logic [5:0] D_Y = 6'(T_YELLOW);
    localparam logic [5:0] D_R = 6'(T_ALLRED);
    localparam logic [5:0] D_P = 6'(T_PED);

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        RED1 = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
`ifdef NIGHT_MODE_EN
        RED2 = 3'd5,
        FLASH = 3'd6
`else
        RED2 = 3'd5
`endif
    } state_t;

    state_t        state;
    state_t        st_n;
    logic [5:0]    rem_n;
    logic          ped_q;
    logic          ped_n;
    logic [5:0]    lamp_n;
    logic          green;
    logic [DW-1:0] div;
`ifdef NIGHT_MODE_EN
    logic          blink;
    logic          blink_n;
`endif

    function automatic state_t succ(input state_t s);
        state_t r;
        unique case (s)
            NS_G:    r = NS_Y;
            NS_Y:    r = RED1;
            RED1:    r = EW_G;
            EW_G:    r = EW_Y;
            EW_Y:    r = RED2;
            default: r = NS_G;
        endcase
        return r;
    endfunction

    function automatic logic [5:0] dur(input state_t s);
        logic [5:0] r;
        unique case (s)
            NS_G, EW_G: r = D_G;
            NS_Y, EW_Y: r = D_Y;
            default:    r = D_R;
        endcase
        return r;
    endfunction

    // {ns, ew} lamps, each {red,yellow,green}
    function automatic logic [5:0] lamps(input state_t s);
        logic [5:0] r;
        unique case (s)
            NS_G:    r = {3'b001, 3'b100};
            NS_Y:    r = {3'b010, 3'b100};
            EW_G:    r = {3'b100, 3'b001};
            EW_Y:    r = {3'b100, 3'b010};
            default: r = {3'b100, 3'b100};
        endcase
        return r;
    endfunction

    assign green    = (state == NS_G) || (state == EW_G);
    assign sec_tick = en && (div == DIV_MAX);
    assign phase    = state;

    // 1 Hz divider; wraps on the same edge that consumes the tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (en) begin
            div <= sec_tick ? '0 : div + DW'(1);
        end
    end

    // next phase, countdown and ped latch; a fresh request always re-arms
    always_comb begin
        st_n   = state;
        rem_n  = remain;
        ped_n  = ped_q;
        lamp_n = {ns_light, ew_light};
`ifdef NIGHT_MODE_EN
        blink_n = blink;
`endif
        if (en) begin
            ped_n = ped_q | ped_req;
            if (green && ped_q) begin
                ped_n = ped_req;
            end
`ifdef NIGHT_MODE_EN
            if (state == FLASH) begin
                ped_n = 1'b0;
                if (sec_tick) begin
                    if (night) begin
                        blink_n = ~blink;
                    end else begin
                        st_n  = RED1;
                        rem_n = D_R;
                    end
                end
            end else if (sec_tick && night) begin
                st_n    = FLASH;
                rem_n   = 6'd0;
                ped_n   = 1'b0;
                blink_n = 1'b1;
            end else
`endif
            if (sec_tick && remain == 6'd1) begin
                st_n  = succ(state);
                rem_n = dur(st_n);
                if (green) begin
                    ped_n = ped_req;
                end
            end else if (green && ped_q && remain > D_P) begin
                rem_n = D_P;
            end else if (sec_tick) begin
                rem_n = remain - 6'd1;
            end
            lamp_n = lamps(st_n);
`ifdef NIGHT_MODE_EN
            if (st_n == FLASH) begin
                lamp_n = {1'b0, blink_n, 1'b0, 1'b0, blink_n, 1'b0};
            end
`endif
        end
    end

    // phase register with registered lamps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= NS_G;
            remain   <= D_G;
            ped_q    <= 1'b0;
            ns_light <= 3'b001;
            ew_light <= 3'b100;
`ifdef NIGHT_MODE_EN
            blink    <= 1'b0;
`endif
        end else begin
            state                <= st_n;
            remain               <= rem_n;
            ped_q                <= ped_n;
            {ns_light, ew_light} <= lamp_n;
`ifdef NIGHT_MODE_EN
            blink                <= blink_n;
`endif
        end
    end

endmodule
